uart_rx_buffer: RTL and testbench

- Downstream consumer of the UART receive path.
- Takes the parallel word and the received parity bit from the RX shift register, qualified by the one-cycle ready pulse from the RX control FSM.
- Checks parity and stores word plus error flag in a first-word-fall-through FIFO.
- Presents entries to the host side with a valid/ready handshake, and keeps sticky overrun status plus a saturating parity-error counter.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_buffer_if.sv | 40 ++++
 rtl/rx_fifo_core.sv | 70 +++++++
 rtl/uart_rx_buffer.sv | 92 +++++++++
 tb/tb_uart_rx_buffer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the RX buffer and the RX/TX datapaths.
//   DEFAULT_WORD_LENGTH : default data bits per frame
//   MAX_WORD_LENGTH     : widest word the parity helper accepts
//   PARITY_EVEN/ODD     : parity mode selectors
//   expected_parity()   : parity bit a well-formed frame carries for a given word
package uart_pkg;

    localparam int unsigned DEFAULT_WORD_LENGTH = 8;
    localparam int unsigned MAX_WORD_LENGTH     = 16;

    localparam bit PARITY_EVEN = 1'b0;
    localparam bit PARITY_ODD  = 1'b1;

    // Callers zero-extend narrower words; zero bits leave the XOR unchanged.
    function automatic logic expected_parity(input logic [MAX_WORD_LENGTH-1:0] data,
                                             input bit                         odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Handshake bundle between the RX path, the RX buffer and the host consumer.
//   rx_data/rx_parity/rx_ready : frame from the RX shift register, qualified by rx_ready
//   out_valid/out_data/out_parity_err/out_ready : FWFT head entry with valid/ready
// Modports: master = environment side (drives rx_* and out_ready),
//           slave  = buffer side (consumes rx_*, presents out_*).
interface uart_rx_buffer_if
    import uart_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = DEFAULT_WORD_LENGTH
) ();

    logic [WORD_LENGTH-1:0] rx_data;
    logic                   rx_parity;
    logic                   rx_ready;
    logic                   out_valid;
    logic [WORD_LENGTH-1:0] out_data;
    logic                   out_parity_err;
    logic                   out_ready;

    modport master (
        output rx_data,
        output rx_parity,
        output rx_ready,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_parity_err
    );

    modport slave (
        input  rx_data,
        input  rx_parity,
        input  rx_ready,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_parity_err
    );

endinterface

// File: rtl/rx_fifo_core.sv
// Generic synchronous first-word-fall-through FIFO.
//   clk, reset       : clock, synchronous active-high reset (discards contents)
//   push, push_data  : write request; accepted when not full, or full with a pop
//   pop              : read request; ignored when empty
//   pop_data         : head entry, 0 when empty
//   push_fire/pop_fire : the requests actually taken this cycle
//   count/full/empty : occupancy
// A pushed entry becomes visible on pop_data the cycle after the push.
module rx_fifo_core #(
    parameter int unsigned WIDTH     = 9,
    parameter int unsigned DEPTH     = 8,
    localparam int unsigned PTR_WIDTH = $clog2(DEPTH),
    localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     pop_data,
    output logic                 push_fire,
    output logic                 pop_fire,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 full,
    output logic                 empty
);

    logic [PTR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [WIDTH-1:0]     mem_q [DEPTH];

    // Occupancy comes from the counter; pointers alone cannot tell full from empty.
    always_comb begin
        full      = (count_q == CNT_WIDTH'(DEPTH));
        empty     = (count_q == '0);
        pop_fire  = pop & ~empty;
        // When full, a same-cycle pop frees the slot the push writes into.
        push_fire = push & (~full | pop_fire);
        pop_data  = empty ? '0 : mem_q[rd_ptr_q];
        count     = count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
            end
            if (pop_fire) begin
                rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
            end
            if (push_fire && !pop_fire) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end else if (pop_fire && !push_fire) begin
                count_q <= count_q - CNT_WIDTH'(1);
            end
        end
    end

    // Storage has no reset; a write landing during reset is unreachable afterwards.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: parity-checks each received word, queues {parity_err, data}
// in an FWFT FIFO and presents it to the host with valid/ready.
//   clk, reset   : clock, synchronous active-high reset
//   bus          : uart_rx_buffer_if.slave (rx_* from the RX path, out_* to the host)
//   clear_status : one-cycle pulse clearing overrun and err_count
//   full/empty/count : FIFO occupancy
//   overrun      : sticky, a frame arrived while full and was dropped
//   err_count    : saturating count of frames received with bad parity
module uart_rx_buffer #(
    parameter int unsigned WORD_LENGTH   = uart_pkg::DEFAULT_WORD_LENGTH,
    parameter int unsigned DEPTH         = 8,
    parameter bit          PARITY_ODD    = uart_pkg::PARITY_EVEN,
    parameter int unsigned ERR_CNT_WIDTH = 8,
    localparam int unsigned CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    uart_rx_buffer_if.slave          bus,
    input  logic                     clear_status,
    output logic                     full,
    output logic                     empty,
    output logic [CNT_WIDTH-1:0]     count,
    output logic                     overrun,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    import uart_pkg::*;

    localparam int unsigned ENTRY_WIDTH = WORD_LENGTH + 1;

    logic                     perr;
    logic [ENTRY_WIDTH-1:0]   head;
    logic                     push_fire;
    logic                     pop_fire;
    logic                     overrun_q, overrun_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

    assign perr = bus.rx_parity !=
                  expected_parity(MAX_WORD_LENGTH'(bus.rx_data), PARITY_ODD);

    rx_fifo_core #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.rx_ready),
        .push_data ({perr, bus.rx_data}),
        .pop       (bus.out_ready),
        .pop_data  (head),
        .push_fire (push_fire),
        .pop_fire  (pop_fire),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign bus.out_valid      = ~empty;
    assign bus.out_data       = head[WORD_LENGTH-1:0];
    assign bus.out_parity_err = head[WORD_LENGTH];

    // Clear is applied first so an event in the same cycle still registers.
    always_comb begin
        overrun_d   = clear_status ? 1'b0 : overrun_q;
        err_count_d = clear_status ? '0 : err_count_q;
        if (bus.rx_ready && !push_fire) begin
            overrun_d = 1'b1;
        end
        // Dropped frames still count towards the error total.
        if (bus.rx_ready && perr && (err_count_d != '1)) begin
            err_count_d = err_count_d + ERR_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            overrun_q   <= overrun_d;
            err_count_q <= err_count_d;
        end
    end

    assign overrun   = overrun_q;
    assign err_count = err_count_q;

    // pop_fire is only needed inside the FIFO; keep the connection explicit.
    logic unused_pop_fire;
    assign unused_pop_fire = pop_fire;

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear_status;
    logic       clear_status_odd;
    logic       full, empty, overrun;
    logic [3:0] count;
    logic [7:0] err_count;
    logic       full_o, empty_o, overrun_o;
    logic [3:0] count_o;
    logic [7:0] err_count_o;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    uart_rx_buffer_if #(.WORD_LENGTH(8)) bus_even ();
    uart_rx_buffer_if #(.WORD_LENGTH(8)) bus_odd ();

    uart_rx_buffer #(
        .WORD_LENGTH   (8),
        .DEPTH         (8),
        .PARITY_ODD    (1'b0),
        .ERR_CNT_WIDTH (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_even),
        .clear_status (clear_status),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overrun      (overrun),
        .err_count    (err_count)
    );

    uart_rx_buffer #(
        .WORD_LENGTH   (8),
        .DEPTH         (8),
        .PARITY_ODD    (1'b1),
        .ERR_CNT_WIDTH (8)
    ) dut_odd (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_odd),
        .clear_status (clear_status_odd),
        .full         (full_o),
        .empty        (empty_o),
        .count        (count_o),
        .overrun      (overrun_o),
        .err_count    (err_count_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle rx_ready pulse on the even-mode DUT.
    task automatic push(input logic [7:0] d, input logic p);
        bus_even.rx_data   = d;
        bus_even.rx_parity = p;
        bus_even.rx_ready  = 1'b1;
        tick();
        bus_even.rx_ready  = 1'b0;
    endtask

    task automatic push_odd(input logic [7:0] d, input logic p);
        bus_odd.rx_data   = d;
        bus_odd.rx_parity = p;
        bus_odd.rx_ready  = 1'b1;
        tick();
        bus_odd.rx_ready  = 1'b0;
    endtask

    task automatic pop_one();
        bus_even.out_ready = 1'b1;
        tick();
        bus_even.out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        reset              = 1'b1;
        clear_status       = 1'b0;
        clear_status_odd   = 1'b0;
        bus_even.rx_data   = '0;
        bus_even.rx_parity = 1'b0;
        bus_even.rx_ready  = 1'b0;
        bus_even.out_ready = 1'b0;
        bus_odd.rx_data    = '0;
        bus_odd.rx_parity  = 1'b0;
        bus_odd.rx_ready   = 1'b0;
        bus_odd.out_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_valid", 32'(bus_even.out_valid), 0);
        check("rst_data", 32'(bus_even.out_data), 0);
        check("rst_perr", 32'(bus_even.out_parity_err), 0);
        check("rst_full", 32'(full), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_count", 32'(count), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_errcnt", 32'(err_count), 0);

        // Even parity, good frame; no same-cycle bypass
        bus_even.rx_data   = 8'h55;
        bus_even.rx_parity = 1'b0;
        bus_even.rx_ready  = 1'b1;
        #1;
        check("no_bypass", 32'(bus_even.out_valid), 0);
        tick();
        bus_even.rx_ready = 1'b0;
        check("p55_valid", 32'(bus_even.out_valid), 1);
        check("p55_data", 32'(bus_even.out_data), 32'h55);
        check("p55_perr", 32'(bus_even.out_parity_err), 0);
        check("p55_count", 32'(count), 1);
        pop_one();
        check("p55_empty", 32'(empty), 1);
        check("p55_data0", 32'(bus_even.out_data), 0);

        // Even parity, bad frame (0x07 has three ones, parity 1 expected)
        push(8'h07, 1'b0);
        check("p07_data", 32'(bus_even.out_data), 32'h07);
        check("p07_perr", 32'(bus_even.out_parity_err), 1);
        check("p07_errcnt", 32'(err_count), 1);
        pop_one();

        // Odd mode
        push_odd(8'h07, 1'b0);
        check("odd07_data", 32'(bus_odd.out_data), 32'h07);
        check("odd07_perr", 32'(bus_odd.out_parity_err), 0);
        check("odd07_errcnt", 32'(err_count_o), 0);
        bus_odd.out_ready = 1'b1;
        tick();
        bus_odd.out_ready = 1'b0;
        push_odd(8'h55, 1'b0);
        check("odd55_perr", 32'(bus_odd.out_parity_err), 1);
        check("odd55_errcnt", 32'(err_count_o), 1);

        // Fill, overrun, drain
        for (int i = 0; i < 8; i++) begin
            d = 8'h10 + 8'(i);
            push(d, ^d);
        end
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), 8);
        check("fill_overrun", 32'(overrun), 0);
        push(8'hAA, 1'b0);
        check("ovr_overrun", 32'(overrun), 1);
        check("ovr_count", 32'(count), 8);
        check("ovr_errcnt", 32'(err_count), 1);
        bus_even.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d", i), 32'(bus_even.out_data), 32'h10 + 32'(i));
            tick();
        end
        bus_even.out_ready = 1'b0;
        check("drain_empty", 32'(empty), 1);
        check("drain_valid", 32'(bus_even.out_valid), 0);
        check("drain_data0", 32'(bus_even.out_data), 0);
        check("drain_overrun", 32'(overrun), 1);

        // Empty with rx_ready and out_ready together: push only
        bus_even.out_ready = 1'b1;
        push(8'h33, 1'b0);
        bus_even.out_ready = 1'b0;
        check("emptypp_count", 32'(count), 1);
        check("emptypp_data", 32'(bus_even.out_data), 32'h33);
        pop_one();

        // clear_status alone
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        check("clr_overrun", 32'(overrun), 0);
        check("clr_errcnt", 32'(err_count), 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            d = 8'h20 + 8'(i);
            push(d, ^d);
        end
        check("fpp_full", 32'(full), 1);
        bus_even.out_ready = 1'b1;
        push(8'h99, 1'b0);
        bus_even.out_ready = 1'b0;
        check("fpp_count", 32'(count), 8);
        check("fpp_overrun", 32'(overrun), 0);
        check("fpp_head", 32'(bus_even.out_data), 32'h21);
        bus_even.out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check($sformatf("fpp_drain%0d", i), 32'(bus_even.out_data), 32'h20 + 32'(i));
            tick();
        end
        check("fpp_last", 32'(bus_even.out_data), 32'h99);
        tick();
        bus_even.out_ready = 1'b0;
        check("fpp_empty", 32'(empty), 1);

        // Saturation and clear-with-event
        bus_even.out_ready = 1'b1;
        bus_even.rx_data   = 8'h07;
        bus_even.rx_parity = 1'b0;
        bus_even.rx_ready  = 1'b1;
        repeat (300) tick();
        check("sat_errcnt", 32'(err_count), 255);
        check("sat_overrun", 32'(overrun), 0);
        clear_status = 1'b1;
        tick();
        clear_status      = 1'b0;
        bus_even.rx_ready = 1'b0;
        check("clrev_errcnt", 32'(err_count), 1);
        tick();
        bus_even.out_ready = 1'b0;
        check("sat_empty", 32'(empty), 1);

        // Synchronous reset mid-operation
        for (int i = 0; i < 8; i++) begin
            d = 8'h30 + 8'(i);
            push(d, ^d);
        end
        push(8'h5A, 1'b0);
        bus_even.out_ready = 1'b1;
        repeat (3) tick();
        bus_even.out_ready = 1'b0;
        check("prerst_count", 32'(count), 5);
        check("prerst_overrun", 32'(overrun), 1);
        reset              = 1'b1;
        bus_even.rx_data   = 8'h44;
        bus_even.rx_parity = 1'b1;
        bus_even.rx_ready  = 1'b1;
        bus_even.out_ready = 1'b1;
        tick();
        reset              = 1'b0;
        bus_even.rx_ready  = 1'b0;
        bus_even.out_ready = 1'b0;
        check("mrst_count", 32'(count), 0);
        check("mrst_empty", 32'(empty), 1);
        check("mrst_valid", 32'(bus_even.out_valid), 0);
        check("mrst_overrun", 32'(overrun), 0);
        check("mrst_errcnt", 32'(err_count), 0);
        check("mrst_odd_errcnt", 32'(err_count_o), 0);
        tick();
        check("mrst_notstored", 32'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
